// File: rtl/uart_rx_os.sv
// Oversampled UART receiver: 2-flop line sync, start/data/parity/stop recovery,
// valid/ready output register with frame/parity error flags and overrun pulse.
module uart_rx_os #(
    parameter int DBIT    = 8,
    parameter int OVS     = 16,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_tick,
    input  logic            rx,
    input  logic            parity_en,
    input  logic            parity_odd,
    output logic [DBIT-1:0] rx_data,
    output logic            rx_valid,
    input  logic            rx_ready,
    output logic            frame_err,
    output logic            parity_err,
    output logic            overrun
);

    localparam int SMAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int SW   = $clog2(SMAX);
    localparam int NW   = $clog2(DBIT);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t          state, state_n;
    logic [SW-1:0]   s, s_n;
    logic [NW-1:0]   n, n_n;
    logic [DBIT-1:0] sreg, sreg_n;
    logic            pen_l, pen_n;
    logic            podd_l, podd_n;
    logic            perr_l, perr_n;
    logic            brk, brk_n;
    logic            rx_q1, rx_s;
    logic            load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_q1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            rx_q1 <= rx;
            rx_s  <= rx_q1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            s      <= '0;
            n      <= '0;
            sreg   <= '0;
            pen_l  <= 1'b0;
            podd_l <= 1'b0;
            perr_l <= 1'b0;
            brk    <= 1'b0;
        end else begin
            state  <= state_n;
            s      <= s_n;
            n      <= n_n;
            sreg   <= sreg_n;
            pen_l  <= pen_n;
            podd_l <= podd_n;
            perr_l <= perr_n;
            brk    <= brk_n;
        end
    end

    always_comb begin
        state_n = state;
        s_n     = s;
        n_n     = n;
        sreg_n  = sreg;
        pen_n   = pen_l;
        podd_n  = podd_l;
        perr_n  = perr_l;
        brk_n   = brk;
        load    = 1'b0;
        case (state)
            IDLE: begin
                // After a stop bit sampled low, the line must return high before a new start is accepted.
                if (brk) begin
                    if (rx_s) brk_n = 1'b0;
                end else if (!rx_s) begin
                    state_n = START;
                    s_n     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == SW'(OVS/2 - 1)) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            s_n     = '0;
                            n_n     = '0;
                            pen_n   = parity_en;
                            podd_n  = parity_odd;
                            perr_n  = 1'b0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == SW'(OVS - 1)) begin
                        s_n    = '0;
                        sreg_n = {rx_s, sreg[DBIT-1:1]};
                        if (n == NW'(DBIT - 1)) state_n = pen_l ? PARITY : STOP;
                        else                    n_n = n + 1'b1;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s == SW'(OVS - 1)) begin
                        perr_n  = ((^sreg) ^ rx_s) != podd_l;
                        state_n = STOP;
                        s_n     = '0;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == SW'(SB_TICK - 1)) begin
                        load    = 1'b1;
                        brk_n   = ~rx_s;
                        state_n = IDLE;
                        s_n     = '0;
                    end else begin
                        s_n = s + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (load) begin
                rx_data    <= sreg;
                frame_err  <= ~rx_s;
                parity_err <= pen_l & perr_l;
                rx_valid   <= 1'b1;
                overrun    <= rx_valid & ~rx_ready;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: frames are driven bit by bit with s_tick tied high
// (16 clk per bit) and every accepted word is captured by a negedge monitor.
module tb_uart_rx_os;

    logic       clk = 1'b0;
    logic       rst, s_tick, rx, parity_en, parity_odd, rx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, parity_err, overrun;

    uart_rx_os #(.DBIT(8), .OVS(16), .SB_TICK(16)) dut (
        .clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx),
        .parity_en(parity_en), .parity_odd(parity_odd),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .parity_err(parity_err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         words = 0, ov_pulses = 0, t_rise = 0;
    logic [7:0] last_data = '0;
    logic       last_fe = 1'b0, last_pe = 1'b0, prev_v = 1'b0;

    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            words     <= words + 1;
            last_data <= rx_data;
            last_fe   <= frame_err;
            last_pe   <= parity_err;
        end
        if (overrun) ov_pulses <= ov_pulses + 1;
        if (rx_valid && !prev_v) t_rise <= cyc;
        prev_v <= rx_valid;
    end

    int checks = 0, passes = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // All drive tasks start and end 1 ns after a rising edge.
    task automatic idle(input int ncyc);
        repeat (ncyc) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        idle(16);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic with_par, input logic pbit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (with_par) send_bit(pbit);
        send_bit(1'b1);
    endtask

    task automatic expect_word(input string tag, input int nwords, input logic [7:0] d,
                               input logic fe, input logic pe);
        check({tag, "_count"}, 32'(words), 32'(nwords));
        check({tag, "_data"},  32'(last_data), 32'(d));
        check({tag, "_ferr"},  32'(last_fe), 32'(fe));
        check({tag, "_perr"},  32'(last_pe), 32'(pe));
    endtask

    int t0, lat, ov0;

    initial begin
        rx = 1'b1; rst = 1'b1; s_tick = 1'b1;
        parity_en = 1'b0; parity_odd = 1'b0; rx_ready = 1'b1;
        idle(3);
        check("rst_data",   32'(rx_data), 32'h0);
        check("rst_valid",  32'(rx_valid), 32'h0);
        check("rst_ferr",   32'(frame_err), 32'h0);
        check("rst_perr",   32'(parity_err), 32'h0);
        check("rst_ovr",    32'(overrun), 32'h0);
        rst = 1'b0;
        idle(5);

        // Basic frame and start-to-valid latency.
        t0 = cyc;
        send_frame(8'hA5, 1'b0, 1'b0);
        expect_word("basic", 1, 8'hA5, 1'b0, 1'b0);
        lat = t_rise - t0;
        check("basic_latency_in_153_156", 32'(lat >= 153 && lat <= 156), 32'h1);
        idle(5);
        check("basic_single_pulse", 32'(words), 32'd1);
        check("basic_valid_low", 32'(rx_valid), 32'h0);

        // Short low glitch is rejected at mid start bit.
        rx = 1'b0; idle(4); rx = 1'b1;
        idle(40);
        check("glitch_no_word", 32'(words), 32'd1);
        check("glitch_no_valid", 32'(rx_valid), 32'h0);
        send_frame(8'h3C, 1'b0, 1'b0);
        expect_word("after_glitch", 2, 8'h3C, 1'b0, 1'b0);

        // 0x07 has three ones: odd parity is satisfied by parity bit 0, even by parity bit 1.
        parity_en = 1'b1; parity_odd = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0);
        expect_word("odd_p0", 3, 8'h07, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b1);
        expect_word("odd_p1", 4, 8'h07, 1'b0, 1'b1);
        parity_odd = 1'b0;
        send_frame(8'h07, 1'b1, 1'b1);
        expect_word("even_p1", 5, 8'h07, 1'b0, 1'b0);
        send_frame(8'h07, 1'b1, 1'b0);
        expect_word("even_p0", 6, 8'h07, 1'b0, 1'b1);
        parity_en = 1'b0;

        // Break: one word with data 0 and frame error.
        rx = 1'b0; idle(300); rx = 1'b1;
        idle(40);
        expect_word("break", 7, 8'h00, 1'b1, 1'b0);
        send_frame(8'h55, 1'b0, 1'b0);
        expect_word("after_break", 8, 8'h55, 1'b0, 1'b0);

        // Overrun: two back-to-back frames with no consumer.
        rx_ready = 1'b0;
        ov0 = ov_pulses;
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        idle(3);
        check("ovr_valid_held", 32'(rx_valid), 32'h1);
        check("ovr_data", 32'(rx_data), 32'h22);
        check("ovr_one_pulse", 32'(ov_pulses - ov0), 32'd1);
        check("ovr_no_transfer", 32'(words), 32'd8);
        rx_ready = 1'b1;
        idle(1);
        check("ovr_valid_drop", 32'(rx_valid), 32'h0);
        check("ovr_accepted_data", 32'(last_data), 32'h22);
        check("ovr_accepted_count", 32'(words), 32'd9);

        // Reset during data bit 3 of 0xFF.
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rx = 1'b1;
        idle(8);
        rst = 1'b1;
        #1;
        check("midrst_data", 32'(rx_data), 32'h0);
        check("midrst_valid", 32'(rx_valid), 32'h0);
        check("midrst_ferr", 32'(frame_err), 32'h0);
        idle(2);
        rst = 1'b0;
        idle(100);
        check("midrst_no_word", 32'(words), 32'd9);
        send_frame(8'h81, 1'b0, 1'b0);
        expect_word("after_rst", 10, 8'h81, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
